// File: rtl/counter_sched_pkg.sv
// counter_sched_pkg
//   Definitions shared by the counter scheduler and its counter datapath:
//   the scheduler FSM state encoding, the direction constants, and a
//   ceiling-log2 helper used to size the requester ID.
package counter_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CLR  = 2'd2,
    ST_DONE = 2'd3
  } sched_state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Ceiling log2 for elaboration-time sizing; clog2(1) is 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/counter_sched_counter.sv
// updown_wrap_counter
//   WIDTH-bit up/down counter with modular wrap-around and a synchronous
//   parallel load. Load has priority over counting.
// Ports:
//   clk      in   clock
//   reset    in   synchronous, active-high; clears count to 0
//   en       in   step the counter this cycle
//   up       in   1 = increment, 0 = decrement
//   load     in   load load_val this cycle
//   load_val in   WIDTH value to load
//   count    out  WIDTH current count
module updown_wrap_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  // NOTE: clocked state is always assigned with <= so every flop samples
  // the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en) begin
      // Plain WIDTH-bit add/subtract: all-ones + 1 wraps to 0 and
      // 0 - 1 wraps to all-ones without any extra compare.
      r_count <= up ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/counter_sched.sv
// counter_sched
//   Round-robin scheduler sharing one up/down wrap-around counter among
//   NUM_REQ requesters. A granted job steps the counter len times in its
//   direction (len = 0 means clear: load 0 for up, all-ones for down),
//   then done pulses for one cycle with the owner's ID.
// Ports:
//   clk        in   clock
//   reset      in   synchronous, active-high; aborts any job
//   req_valid  in   NUM_REQ        per-requester job pending
//   req_dir    in   NUM_REQ        per-requester direction, 1 = up
//   req_len    in   NUM_REQ*LEN_W  packed lengths, requester i at [i*LEN_W +: LEN_W]
//   grant      out  NUM_REQ        one-hot accept strobe, only in IDLE
//   busy       out  1              high in every state except IDLE
//   done       out  1              one-cycle job completion pulse
//   done_id    out  ID_W           owner of the completed job
//   count      out  WIDTH          shared counter value
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int LEN_W   = 4,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_dir,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic                     done,
  output logic [ID_W-1:0]          done_id,
  output logic [WIDTH-1:0]         count
);

  sched_state_t     r_state;
  logic [ID_W-1:0]  r_last_winner;
  logic [ID_W-1:0]  r_id;
  logic             r_dir;
  logic [LEN_W-1:0] r_remain;
  logic             r_done;
  logic [ID_W-1:0]  r_done_id;

  logic             w_found;
  logic [ID_W-1:0]  w_win_idx;
  logic [LEN_W-1:0] w_win_len;
  int               w_idx;

  // ---------------------------------------------------------------------
  // Round-robin arbiter: scan from last_winner+1 around the ring and take
  // the first pending requester. Reset puts last_winner at NUM_REQ-1 so
  // requester 0 is checked first.
  // ---------------------------------------------------------------------
  // NOTE: every variable written here gets a default before any condition,
  // so no path leaves a value held and no latch is inferred.
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    w_idx     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = int'(r_last_winner) + i;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_found && req_valid[w_idx]) begin
        w_found   = 1'b1;
        w_win_idx = w_idx[ID_W-1:0];
      end
    end
  end

  assign w_win_len = req_len[w_win_idx*LEN_W +: LEN_W];

  // Accepting edge is any IDLE cycle with a winner; the strobe is decoded
  // from state so a held req_valid cannot win again during DONE.
  assign grant = (r_state == ST_IDLE && w_found) ? (NUM_REQ'(1) << w_win_idx)
                                                 : '0;

  // ---------------------------------------------------------------------
  // Scheduler FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_last_winner <= ID_W'(NUM_REQ - 1);
      r_id          <= '0;
      r_dir         <= DIR_DOWN;
      r_remain      <= '0;
      r_done        <= 1'b0;
      r_done_id     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_dir         <= req_dir[w_win_idx];
            r_remain      <= w_win_len;
            r_id          <= w_win_idx;
            r_last_winner <= w_win_idx;
            r_state       <= (w_win_len != '0) ? ST_RUN : ST_CLR;
          end
        end
        ST_RUN: begin
          r_remain <= r_remain - LEN_W'(1);
          if (r_remain == LEN_W'(1)) begin
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_done_id <= r_id;
          end
        end
        ST_CLR: begin
          r_state   <= ST_DONE;
          r_done    <= 1'b1;
          r_done_id <= r_id;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Counter datapath: steps in RUN, loads the clear value in CLR.
  // ---------------------------------------------------------------------
  logic             w_cnt_en;
  logic             w_cnt_load;
  logic [WIDTH-1:0] w_clr_val;

  assign w_cnt_en   = (r_state == ST_RUN);
  assign w_cnt_load = (r_state == ST_CLR);
  assign w_clr_val  = (r_dir == DIR_UP) ? '0 : '1;

  updown_wrap_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .en       (w_cnt_en),
    .up       (r_dir),
    .load     (w_cnt_load),
    .load_val (w_clr_val),
    .count    (count)
  );

  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;
  assign done_id = r_done_id;

endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched
//   Directed bench for counter_sched with the default parameters
//   (4 requesters, 4-bit counter, 4-bit lengths). Inputs are driven and
//   outputs sampled 1 time unit after the rising edge.
module tb_counter_sched;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 4;
  localparam int LEN_W   = 4;
  localparam int ID_W    = 2;

  logic                     clk;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_dir;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic                     done;
  logic [ID_W-1:0]          done_id;
  logic [WIDTH-1:0]         count;

  int n_vec  = 0;
  int n_fail = 0;

  counter_sched #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .LEN_W   (LEN_W),
    .ID_W    (ID_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_dir   (req_dir),
    .req_len   (req_len),
    .grant     (grant),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_job(input int idx, input logic dir,
                         input logic [LEN_W-1:0] len);
    req_valid[idx]              = 1'b1;
    req_dir[idx]                = dir;
    req_len[idx*LEN_W +: LEN_W] = len;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_dir   = '0;
    req_len   = '0;
    tick();
    tick();

    // Reset state
    check("rst_count",   32'(count),   32'h0);
    check("rst_busy",    32'(busy),    32'h0);
    check("rst_done",    32'(done),    32'h0);
    check("rst_done_id", 32'(done_id), 32'h0);
    check("rst_grant",   32'(grant),   32'h0);
    reset = 1'b0;

    // Single up job: req0 up len 3
    set_job(0, 1'b1, 4'd3);
    #1;
    check("up_grant", 32'(grant), 32'b0001);
    tick();                                   // T+1
    req_valid = '0;
    check("up_busy",   32'(busy),  32'h1);
    check("up_c_t1",   32'(count), 32'd0);
    check("up_gnt_rn", 32'(grant), 32'h0);
    tick();                                   // T+2
    check("up_c_t2",   32'(count), 32'd1);
    tick();                                   // T+3
    check("up_c_t3",   32'(count), 32'd2);
    check("up_nodone", 32'(done),  32'h0);
    tick();                                   // T+4
    check("up_c_t4",   32'(count),   32'd3);
    check("up_done",   32'(done),    32'h1);
    check("up_id",     32'(done_id), 32'd0);
    tick();                                   // T+5
    check("up_idle",   32'(busy),  32'h0);
    check("up_dn_lo",  32'(done),  32'h0);
    check("up_hold",   32'(count), 32'd3);

    // Clear to 0 (req0 up clear), then down wrap with req1 len 2
    set_job(0, 1'b1, 4'd0);
    #1;
    check("clr0_grant", 32'(grant), 32'b0001);
    tick();
    req_valid = '0;
    tick();
    check("clr0_count", 32'(count), 32'd0);
    tick();

    set_job(1, 1'b0, 4'd2);
    #1;
    check("dn_grant", 32'(grant), 32'b0010);
    tick();
    req_valid = '0;
    check("dn_c_t1", 32'(count), 32'd0);
    tick();
    check("dn_c_t2", 32'(count), 32'd15);
    tick();
    check("dn_c_t3", 32'(count),   32'd14);
    check("dn_done", 32'(done),    32'h1);
    check("dn_id",   32'(done_id), 32'd1);
    tick();

    // Clear jobs on req2: down-clear then up-clear
    set_job(2, 1'b0, 4'd0);
    #1;
    check("clrd_grant", 32'(grant), 32'b0100);
    tick();                                   // T+1 (CLR)
    req_valid = '0;
    check("clrd_busy", 32'(busy),  32'h1);
    check("clrd_t1",   32'(count), 32'd14);
    tick();                                   // T+2 (DONE)
    check("clrd_t2",   32'(count),   32'd15);
    check("clrd_done", 32'(done),    32'h1);
    check("clrd_id",   32'(done_id), 32'd2);
    tick();
    check("clrd_idle", 32'(busy), 32'h0);

    set_job(2, 1'b1, 4'd0);
    #1;
    check("clru_grant", 32'(grant), 32'b0100);
    tick();
    req_valid = '0;
    tick();
    check("clru_t2",   32'(count), 32'd0);
    check("clru_done", 32'(done),  32'h1);
    tick();

    // Round-robin fairness from a fresh reset: all four held, len 1 up
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rr_rst_count", 32'(count), 32'd0);
    req_valid = 4'b1111;
    req_dir   = 4'b1111;
    req_len   = 16'h1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("rr_grant_%0d", k), 32'(grant), 32'(1 << (k % 4)));
      tick();                                 // RUN
      tick();                                 // DONE
      check($sformatf("rr_done_%0d", k),  32'(done),    32'h1);
      check($sformatf("rr_id_%0d", k),    32'(done_id), 32'(k % 4));
      check($sformatf("rr_count_%0d", k), 32'(count),   32'(k + 1));
      check($sformatf("rr_nogrant_%0d", k), 32'(grant), 32'h0);
      tick();                                 // back in IDLE
    end
    req_valid = '0;

    // Up wrap: bring count to 14 (down-clear to 15, one down step)
    set_job(1, 1'b0, 4'd0);
    #1;
    check("w_clr_grant", 32'(grant), 32'b0010);
    tick();
    req_valid = '0;
    tick();
    check("w_clr_count", 32'(count), 32'd15);
    tick();

    set_job(2, 1'b0, 4'd1);
    #1;
    check("w_dn_grant", 32'(grant), 32'b0100);
    tick();
    req_valid = '0;
    tick();
    check("w_dn_count", 32'(count), 32'd14);
    tick();

    set_job(3, 1'b1, 4'd4);
    #1;
    check("w_up_grant", 32'(grant), 32'b1000);
    tick();
    req_valid = '0;
    check("w_up_t1", 32'(count), 32'd14);
    tick();
    check("w_up_t2", 32'(count), 32'd15);
    tick();
    check("w_up_t3", 32'(count), 32'd0);
    tick();
    check("w_up_t4", 32'(count), 32'd1);
    tick();
    check("w_up_t5",   32'(count),   32'd2);
    check("w_up_done", 32'(done),    32'h1);
    check("w_up_id",   32'(done_id), 32'd3);
    tick();

    // Reset mid-RUN: req0 up len 10 starting from count 2
    set_job(0, 1'b1, 4'd10);
    #1;
    check("mr_grant", 32'(grant), 32'b0001);
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    tick();                                   // four steps taken
    check("mr_pre_count", 32'(count), 32'd6);
    check("mr_pre_busy",  32'(busy),  32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_count", 32'(count), 32'd0);
    check("mr_busy",  32'(busy),  32'h0);
    check("mr_done",  32'(done),  32'h0);
    tick();
    check("mr_done_p1", 32'(done), 32'h0);
    tick();
    check("mr_done_p2", 32'(done), 32'h0);

    // Pointer restarted at 0: with req0 and req3 pending, req0 wins
    set_job(0, 1'b1, 4'd1);
    set_job(3, 1'b1, 4'd1);
    #1;
    check("mr_rr_grant0", 32'(grant), 32'b0001);
    tick();
    req_valid = 4'b1000;
    tick();
    check("mr_rr_id0",   32'(done_id), 32'd0);
    check("mr_rr_cnt0",  32'(count),   32'd1);
    tick();
    check("mr_rr_grant3", 32'(grant), 32'b1000);
    tick();
    req_valid = '0;
    tick();
    check("mr_rr_done3", 32'(done),    32'h1);
    check("mr_rr_id3",   32'(done_id), 32'd3);
    check("mr_rr_cnt3",  32'(count),   32'd2);
    tick();
    check("mr_end_busy", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_sched.md
Name: counter_sched

Overview:
- Round-robin scheduler that shares one up/down wrap-around counter among NUM_REQ requesters.
- Each requester posts a job: a direction plus a step count, or a clear (step count 0).
- The block grants one job at a time, steps the internal counter for the requested number of cycles, then pulses done with the owner's ID.
- It sits between software-visible command sources and the shared count value consumed downstream.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 4, counter width.
- LEN_W, 4, width of each job length field.
- ID_W, 2, width of done_id; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester job pending.
- req_dir  in  NUM_REQ  per-requester direction; 1 = up, 0 = down.
- req_len  in  NUM_REQ*LEN_W  packed job lengths; requester i occupies bits [i*LEN_W +: LEN_W]; 0 = clear job.
- grant  out  NUM_REQ  one-hot; job i is accepted on the edge where grant[i] is high.
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle pulse when a job completes.
- done_id  out  ID_W  requester index of the completed job; valid while done is high.
- count  out  WIDTH  current counter value.

Behaviour:
- Reset values: state IDLE, count 0, grant 0, busy 0, done 0, done_id 0, RR pointer such that requester 0 has highest priority first.
- FSM states: IDLE, RUN, CLR, DONE.
- IDLE, arbitration:
  - grant is combinational from req_valid and the RR pointer, and is only nonzero in IDLE.
  - The winner is the first requester with req_valid high, searching from (last_winner+1) mod NUM_REQ.
  - On the accepting edge (cycle T): latch dir, len and id; update last_winner.
  - Next state is RUN if len != 0, CLR if len == 0.
  - Requesters must drop or replace req_valid after seeing grant. A still-high req_valid is treated as a new job.
- RUN: the counter steps once per cycle for exactly len cycles (T+1 .. T+len).
  - Up: count+1; 2^WIDTH-1 wraps to 0.
  - Down: count-1; 0 wraps to 2^WIDTH-1.
  - Remaining-steps register decrements each cycle; on the last step the next state is DONE.
- CLR: single cycle, T+1. Count loads 0 if dir=1, all-ones if dir=0. Next state is DONE.
- DONE: done=1 and done_id=latched id for one cycle; count holds its final value; next state is IDLE.
- Latency: a len=L job occupies L+2 cycles from grant to the first cycle back in IDLE. A clear job occupies 3. There is no back-to-back grant in the DONE cycle.
- count changes only in RUN and CLR; it holds in IDLE and DONE.
- Simultaneous requests: exactly one grant per IDLE cycle, chosen per the RR order. The remaining requests wait.
- req_valid, req_dir and req_len changes while busy are ignored; only values sampled at the grant edge matter.
- Maximum len is 2^LEN_W-1 steps. A len of 2^WIDTH or more wraps the counter one or more times, with no error.
- reset mid-job: aborts the job immediately with no done pulse; count returns to 0 and the RR pointer resets.

Decomposition:
- Shared package holds:
  - the FSM state enum (IDLE, RUN, CLR, DONE);
  - the DIR_UP=1 and DIR_DOWN=0 constants;
  - a clog2 helper for ID_W.
- One sub-module, updown_wrap_counter (WIDTH param): inputs clk, reset, en, up, load, load_val; output count.
  - Handles the wrap arithmetic and the synchronous clear-to-0.
  - The scheduler drives load for CLR jobs.
- The round-robin arbiter stays inline: a mask-and-priority-encode of roughly 30 lines.

Test Plan:
- Reset, then a single up job: req_valid=0001, dir0=1, len0=3 → grant=0001 in cycle T; count 1,2,3 after T+1..T+3; done=1, done_id=0 in T+4; busy drops in T+5.
- Down wrap: start count=0, req1 dir=0 len=2 → count 15 then 14; done_id=1.
- Clear jobs: req2 len=0 dir=0 → count=15 after T+1, done at T+2. Then req2 len=0 dir=1 → count=0.
- Round-robin fairness: req_valid=1111 held, len=1 each → grant order 0,1,2,3,0; each grant spaced 3 cycles apart; done_id follows the same order.
- Up wrap across a boundary: count=14, req3 dir=1 len=4 → count 15,0,1,2; done with count=2.
- Reset mid-RUN: len=10 job, reset asserted at step 5 → next cycle count=0, busy=0, no done pulse. A subsequent req_valid=1000 is granted to requester 3 only after the RR pointer has restarted from 0, i.e. requester 3 is granted because no lower-index requester is pending.
